// File: rtl/shift_deserializer_if.sv
// Word-level valid/ready port of the shift deserializer.
// The master offers captured words; the slave accepts them.
interface shift_deserializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] word_data;
    logic             word_valid;
    logic             word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/shift_deserializer.sv
// Serial-to-parallel shift register with word framing, parallel load,
// rotate, serial output and a sticky dropped-word flag.
module shift_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data,
    input  logic                     shift_enable,
    input  logic                     rotate,
    input  logic                     load,
    input  logic [WIDTH-1:0]         load_data,
    input  logic                     clear_overflow,
    output logic [WIDTH-1:0]         stored_data,
    output logic                     serial_out,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     overflow,
    shift_deserializer_if.master     word_if
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_word;
    logic             r_valid;
    logic             r_ovf;

    logic             w_out;
    logic             w_in;
    logic [WIDTH-1:0] w_shifted;
    logic             w_shift;
    logic             w_capture;
    logic             w_xfer;
    logic             w_drop;

    assign w_out = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
    assign w_in  = rotate ? w_out : data;

    generate
        if (MSB_FIRST) begin : g_left
            assign w_shifted = {r_sr[WIDTH-2:0], w_in};
        end else begin : g_right
            assign w_shifted = {w_in, r_sr[WIDTH-1:1]};
        end
    endgenerate

    // Only counted (non-rotating) shifts frame words.
    assign w_shift   = !load && shift_enable;
    assign w_capture = w_shift && !rotate && (r_cnt == LAST);
    assign w_xfer    = r_valid && word_if.word_ready;
    assign w_drop    = w_capture && r_valid && !word_if.word_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_sr  <= load_data;
            r_cnt <= '0;
        end else if (shift_enable) begin
            r_sr <= w_shifted;
            if (!rotate)
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word  <= '0;
            r_valid <= 1'b0;
        end else if (w_capture && (!r_valid || word_if.word_ready)) begin
            r_word  <= w_shifted;
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    // A drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
        else if (clear_overflow)
            r_ovf <= 1'b0;
    end

    assign stored_data        = r_sr;
    assign serial_out         = w_out;
    assign bit_count          = r_cnt;
    assign overflow           = r_ovf;
    assign word_if.word_data  = r_word;
    assign word_if.word_valid = r_valid;
endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench: framing, overflow, same-edge accept, load/rotate,
// LSB-first shifting and asynchronous reset.
module tb_shift_deserializer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       a_data, a_se, a_rot, a_load, a_clr;
    logic [7:0] a_ld;
    logic [7:0] a_sd;
    logic       a_so, a_ov;
    logic [2:0] a_bc;
    shift_deserializer_if #(.WIDTH(8)) a_if ();

    logic       b_data, b_se, b_rot, b_load, b_clr;
    logic [7:0] b_ld;
    logic [7:0] b_sd;
    logic       b_so, b_ov;
    logic [2:0] b_bc;
    shift_deserializer_if #(.WIDTH(8)) b_if ();

    shift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .data(a_data),
        .shift_enable(a_se), .rotate(a_rot), .load(a_load),
        .load_data(a_ld), .clear_overflow(a_clr),
        .stored_data(a_sd), .serial_out(a_so), .bit_count(a_bc),
        .overflow(a_ov), .word_if(a_if)
    );

    shift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .data(b_data),
        .shift_enable(b_se), .rotate(b_rot), .load(b_load),
        .load_data(b_ld), .clear_overflow(b_clr),
        .stored_data(b_sd), .serial_out(b_so), .bit_count(b_bc),
        .overflow(b_ov), .word_if(b_if)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_shift(input logic b);
        a_data = b;
        a_se   = 1'b1;
        tick();
        a_se   = 1'b0;
    endtask

    // Shifts w MSB first; the last bit is left for the caller when n=7.
    task automatic a_bits(input logic [7:0] w, input int n);
        for (int i = 7; i > 7 - n; i--) a_shift(w[i]);
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_sd"}, a_sd, 8'h00);
        chk({tag, "_so"}, a_so, 1'b0);
        chk({tag, "_bc"}, a_bc, 3'd0);
        chk({tag, "_wd"}, a_if.word_data, 8'h00);
        chk({tag, "_wv"}, a_if.word_valid, 1'b0);
        chk({tag, "_ov"}, a_ov, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        a_data = 0; a_se = 0; a_rot = 0; a_load = 0; a_clr = 0;
        a_ld = 8'h00; a_if.word_ready = 1'b0;
        b_data = 0; b_se = 0; b_rot = 0; b_load = 0; b_clr = 0;
        b_ld = 8'h00; b_if.word_ready = 1'b0;
        #1;
        chk_a_zero("rst");
        chk("rst_b_sd", b_sd, 8'h00);
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Framing
        a_bits(8'hB2, 3);
        chk("frame_bc3", a_bc, 3'd3);
        chk("frame_wv3", a_if.word_valid, 1'b0);
        a_bits({3'b0, 5'b10010}, 0);
        a_shift(1'b1); a_shift(1'b0); a_shift(1'b0);
        a_shift(1'b1); a_shift(1'b0);
        chk("frame_sd", a_sd, 8'hB2);
        chk("frame_wd", a_if.word_data, 8'hB2);
        chk("frame_wv", a_if.word_valid, 1'b1);
        chk("frame_bc", a_bc, 3'd0);

        // Overflow: second word dropped
        a_bits(8'h0F, 8);
        chk("ovf_wd", a_if.word_data, 8'hB2);
        chk("ovf_set", a_ov, 1'b1);
        chk("ovf_sd", a_sd, 8'h0F);
        a_clr = 1'b1; tick(); a_clr = 1'b0;
        chk("ovf_clr", a_ov, 1'b0);
        chk("ovf_wv_held", a_if.word_valid, 1'b1);
        a_if.word_ready = 1'b1; tick(); a_if.word_ready = 1'b0;
        chk("accept_wv", a_if.word_valid, 1'b0);
        chk("accept_wd", a_if.word_data, 8'hB2);

        // Same-edge accept and capture
        a_bits(8'h55, 8);
        chk("se_wd55", a_if.word_data, 8'h55);
        a_bits(8'h3C, 7);
        a_if.word_ready = 1'b1;
        a_shift(1'b0);
        a_if.word_ready = 1'b0;
        chk("se_wd", a_if.word_data, 8'h3C);
        chk("se_wv", a_if.word_valid, 1'b1);
        chk("se_ov", a_ov, 1'b0);

        // Drop and clear on the same edge: set wins
        a_bits(8'hFF, 7);
        a_clr = 1'b1;
        a_shift(1'b1);
        a_clr = 1'b0;
        chk("dc_ov", a_ov, 1'b1);
        chk("dc_wd", a_if.word_data, 8'h3C);
        a_clr = 1'b1; tick(); a_clr = 1'b0;
        chk("dc_clr", a_ov, 1'b0);
        a_if.word_ready = 1'b1; tick(); a_if.word_ready = 1'b0;
        chk("dc_wv", a_if.word_valid, 1'b0);

        // Load beats shift, then rotate
        a_shift(1'b1); a_shift(1'b1);
        chk("ld_bc_pre", a_bc, 3'd2);
        a_ld = 8'hA5; a_load = 1'b1; a_se = 1'b1; a_data = 1'b0;
        tick();
        a_load = 1'b0; a_se = 1'b0;
        chk("ld_sd", a_sd, 8'hA5);
        chk("ld_bc", a_bc, 3'd0);
        chk("ld_so", a_so, 1'b1);
        a_rot = 1'b1; a_shift(1'b0); a_rot = 1'b0;
        chk("rot_sd", a_sd, 8'h4B);
        chk("rot_so", a_so, 1'b0);
        chk("rot_bc", a_bc, 3'd0);

        // Rotate at bit_count=7 neither counts nor captures
        a_bits(8'h00, 7);
        chk("r7_sd", a_sd, 8'h80);
        chk("r7_bc", a_bc, 3'd7);
        a_rot = 1'b1; a_shift(1'b0); a_rot = 1'b0;
        chk("r7_rot_sd", a_sd, 8'h01);
        chk("r7_rot_bc", a_bc, 3'd7);
        chk("r7_rot_wv", a_if.word_valid, 1'b0);
        a_shift(1'b1);
        chk("r7_cap_wd", a_if.word_data, 8'h03);
        chk("r7_cap_wv", a_if.word_valid, 1'b1);
        chk("r7_cap_bc", a_bc, 3'd0);

        // LSB-first instance
        b_data = 1'b1; b_se = 1'b1; tick();
        chk("lsb_sd1", b_sd, 8'h80);
        chk("lsb_so1", b_so, 1'b0);
        b_data = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        b_se = 1'b0;
        chk("lsb_sd", b_sd, 8'h01);
        chk("lsb_so", b_so, 1'b1);
        chk("lsb_wd", b_if.word_data, 8'h01);
        chk("lsb_wv", b_if.word_valid, 1'b1);

        // Asynchronous reset mid-word with overflow and word pending
        a_bits(8'hC3, 8);
        chk("ar_ov_pre", a_ov, 1'b1);
        a_bits(8'hA0, 3);
        chk("ar_bc_pre", a_bc, 3'd3);
        #2 reset = 1'b1;
        #1;
        chk_a_zero("arst");
        chk("arst_b_wv", b_if.word_valid, 1'b0);
        #2 reset = 1'b0;
        a_bits(8'h96, 8);
        chk("ar_wd", a_if.word_data, 8'h96);
        chk("ar_wv", a_if.word_valid, 1'b1);
        chk("ar_bc", a_bc, 3'd0);
        chk("ar_ov", a_ov, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Parametrised serial-to-parallel shift register with word framing: shifts serial bits into a WIDTH-bit register and counts them. Each completed WIDTH-bit word is captured into a holding register and offered on a valid/ready output port. Also supports parallel load, rotate and serial output, and reports dropped words. Sits between a serial bit source and word-level consumer logic, replacing the fixed 8-bit shift register in new designs.

## Interface

Parameters:
- WIDTH, 8: register and word width in bits; legal range 2..64.
- MSB_FIRST, 1: shift direction.
  - 1: shift left, data enters bit 0, serial_out = bit WIDTH-1.
  - 0: shift right, data enters bit WIDTH-1, serial_out = bit 0.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- data  input  1  serial input bit.
- shift_enable  input  1  shift one position this cycle.
- rotate  input  1  when shifting, feed the outgoing bit back in instead of data.
- load  input  1  parallel load of load_data; has priority over shift_enable.
- load_data  input  WIDTH  parallel load value.
- clear_overflow  input  1  clears the sticky overflow flag.
- word_ready  input  1  consumer accepts word_data this cycle.
- stored_data  output  WIDTH  live shift register contents.
- serial_out  output  1  bit that leaves on the next shift; combinational from the register.
- bit_count  output  $clog2(WIDTH)  data bits shifted into the current word.
- word_data  output  WIDTH  captured word.
- word_valid  output  1  word_data holds an unconsumed word.
- overflow  output  1  sticky flag: a completed word was dropped.

## Operation

- Reset values: stored_data=0, bit_count=0, word_data=0, word_valid=0, overflow=0. serial_out is therefore 0.
- Per-edge priority for the shift register: load > shift_enable > hold.
- load=1:
  - stored_data <= load_data.
  - bit_count <= 0.
  - No capture occurs.
  - shift_enable is ignored.
- Shift with load=0, shift_enable=1, rotate=0:
  - The register shifts one place in the MSB_FIRST direction; data is the incoming bit.
  - If bit_count == WIDTH-1:
    - This is a capture. The candidate word is the post-shift register value.
    - bit_count <= 0.
  - Otherwise bit_count <= bit_count+1.
- Shift with load=0, shift_enable=1, rotate=1:
  - The register rotates one place; the outgoing bit re-enters.
  - bit_count is unchanged and no capture occurs.
- Output port:
  - A transfer happens on any edge where word_valid=1 and word_ready=1.
  - On a transfer with no capture, word_valid <= 0.
  - On a capture where word_valid=0, or where a transfer happens the same edge: word_data <= candidate, word_valid <= 1.
  - On a capture where word_valid=1 and word_ready=0: the candidate is dropped, word_data is unchanged, overflow <= 1.
- Overflow flag:
  - clear_overflow=1 clears overflow.
  - If a drop occurs on the same edge, the set wins and overflow stays 1.
- word_ready while word_valid=0 has no effect.

## Timing

- All outputs except serial_out are registered. serial_out follows stored_data combinationally.
- Capture latency: word_valid and word_data update on the same edge as the WIDTH-th counted shift.
- Throughput:
  - One word per WIDTH shifts.
  - Back-to-back shifting with word_ready held high never overflows.
  - The consumer has WIDTH cycles minimum to accept a word.
- Asynchronous reset:
  - Asserting reset mid-word forces all registered outputs to reset values without waiting for a clock edge.
  - Deassertion is synchronous to the design clock; the first update follows on the next rising edge after release.
- bit_count wraps WIDTH-1 -> 0 only on a counted shift; otherwise it holds.

## Test plan

- Framing (WIDTH=8, MSB_FIRST=1, word_ready=0):
  - Stimulus: shift in 1,0,1,1,0,0,1,0.
  - Required: after the 8th edge, word_data=8'hB2, word_valid=1, bit_count=0. word_valid drops the edge after word_ready=1.
- Overflow (word_ready=0):
  - Stimulus: shift 16 bits, the first word 8'hB2 and the second 8'h0F.
  - Required: word_data stays 8'hB2 and overflow=1. clear_overflow asserted for one edge -> overflow=0.
- Same-edge accept:
  - Stimulus: with word_valid=1, word_ready=1 on the edge that completes word 8'h3C.
  - Required: word_data=8'h3C, word_valid=1, overflow=0.
- Load and rotate:
  - Stimulus: load=1 with load_data=8'hA5 and shift_enable=1.
  - Required after load: stored_data=8'hA5, bit_count=0.
  - Stimulus: one rotate shift.
  - Required: stored_data=8'h4B. serial_out is 1 before the rotate and 0 after.
- MSB_FIRST=0:
  - Stimulus: shift in 1,0,0,0,0,0,0,0.
  - Required: word_data=8'h01, serial_out tracks bit 0.
- Asynchronous reset:
  - Stimulus: after 3 shifts and with word_valid=1, pulse reset between clock edges.
  - Required: every output reads 0 before the next rising edge. The next 8 shifts produce a complete word again.
